noc_dual_rail_rx_mux: RTL

//  Multi-channel dual-rail NoC-to-synchronous bridge; successor to the single-channel NoC TX capture interface.

---
 rtl/noc_dual_rail_rx_mux.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/noc_dual_rail_rx_mux.sv
// Multi-channel dual-rail 4-phase NoC receiver: per-rail synchronisers, codeword
// completion detect, round-robin arbitration into one FIFO with a valid/ready output.
module noc_dual_rail_rx_mux #(
  parameter  int NOC_WID     = 16,
  parameter  int NUM_CH      = 4,
  parameter  int DEPTH       = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*2*NOC_WID-1:0]  ch_d,
  output logic [NUM_CH-1:0]            ch_ack,
  output logic [NOC_WID-1:0]           out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CNT_W-1:0]             fifo_count,
  output logic [NUM_CH-1:0]            err,
  input  logic [NUM_CH-1:0]            err_clr
);

  localparam int RAIL_W = NUM_CH * 2 * NOC_WID;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACK_HI = 1'b1
  } ch_state_t;

  // ---------------------------------------------------------------------------
  // Rail synchronisers (each rail independent; completion detection tolerates skew)
  // ---------------------------------------------------------------------------
  logic [RAIL_W-1:0] s;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign s = ch_d;
    end else begin : g_sync
      logic [RAIL_W-1:0] sync_q [SYNC_STAGES];

      // NOTE: every flop in a clocked block is assigned with <=, so all stages
      // sample the pre-edge values and the chain shifts by exactly one per clock.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= ch_d;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Codeword decode: 01 -> 0, 10 -> 1, 00 -> spacer, 11 -> illegal
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0]  complete;
  logic [NUM_CH-1:0]  spacer;
  logic [NUM_CH-1:0]  illegal;
  logic [NOC_WID-1:0] word [NUM_CH];

  // NOTE: each output gets a default at the top of the block, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      complete[c] = 1'b1;
      spacer[c]   = 1'b1;
      illegal[c]  = 1'b0;
      word[c]     = '0;
      for (int j = 0; j < NOC_WID; j++) begin
        complete[c] = complete[c] & (s[c*2*NOC_WID + 2*j] ^ s[c*2*NOC_WID + 2*j + 1]);
        spacer[c]   = spacer[c] & ~(s[c*2*NOC_WID + 2*j] | s[c*2*NOC_WID + 2*j + 1]);
        illegal[c]  = illegal[c] | (s[c*2*NOC_WID + 2*j] & s[c*2*NOC_WID + 2*j + 1]);
        word[c][j]  = s[c*2*NOC_WID + 2*j + 1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel handshake state, requests and round-robin arbitration
  // ---------------------------------------------------------------------------
  ch_state_t         state [NUM_CH];
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] err_set;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_valid;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      req[c]     = (state[c] == IDLE) & complete[c] & ~illegal[c];
      err_set[c] = (state[c] == IDLE) & illegal[c];
    end
  end

  // Full FIFO blocks the grant even when a pop happens in the same cycle.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (fifo_count < CNT_W'(DEPTH)) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!grant_valid && req[(int'(rr_ptr) + k) % NUM_CH]) begin
          grant_valid = 1'b1;
          grant_idx   = CH_W'((int'(rr_ptr) + k) % NUM_CH);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) state[c] <= IDLE;
      ch_ack <= '0;
      err    <= '0;
      rr_ptr <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        case (state[c])
          IDLE: begin
            if (grant_valid && (grant_idx == CH_W'(c))) begin
              state[c]  <= ACK_HI;
              ch_ack[c] <= 1'b1;
            end
          end
          ACK_HI: begin
            if (spacer[c]) begin
              state[c]  <= IDLE;
              ch_ack[c] <= 1'b0;
            end
          end
        endcase
      end
      err <= (err & ~err_clr) | err_set;
      if (grant_valid) begin
        rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Circular FIFO with head presented combinationally from storage
  // ---------------------------------------------------------------------------
  logic [NOC_WID-1:0] mem_data [DEPTH];
  logic [CH_W-1:0]    mem_ch   [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [NOC_WID-1:0] last_data;
  logic [CH_W-1:0]    last_ch;
  logic               push;
  logic               pop;

  assign push      = grant_valid;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;

  // NOTE: storage has no reset; entries are only read while counted as valid,
  // and reset clears the pointers and count, which discards the contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= word[grant_idx];
      mem_ch[wr_ptr]   <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      last_data  <= '0;
      last_ch    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      // Remember the head so the outputs hold their last value once empty.
      if (out_valid) begin
        last_data <= mem_data[rd_ptr];
        last_ch   <= mem_ch[rd_ptr];
      end
    end
  end

  assign out_data = out_valid ? mem_data[rd_ptr] : last_data;
  assign out_ch   = out_valid ? mem_ch[rd_ptr]   : last_ch;

endmodule
